// File: rtl/op_seq_pkg.sv
// Shared types and constants for the op_sequencer front-end controller.
package op_seq_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned RES_W = 8;

    localparam logic [RES_W-1:0] LED_TIMEOUT_CODE = 8'hFF;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStart = 3'd2,
        StWait  = 3'd3,
        StShow  = 3'd4
    } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Run-button conditioning: 2-flop synchronizer, debounce counter and re-arm logic.
// Emits one press pulse per clean press, however long the button is held.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] lo_cnt_q, lo_cnt_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;

    // Counters saturate at CNT_MAX so a long hold or long release cannot wrap.
    always_comb begin
        hi_cnt_d = '0;
        lo_cnt_d = '0;
        if (sync2_q) begin
            hi_cnt_d = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CW'(1);
        end else begin
            lo_cnt_d = (lo_cnt_q == CNT_MAX) ? lo_cnt_q : lo_cnt_q + CW'(1);
        end

        press_d = armed_q && (hi_cnt_d == CNT_MAX);

        armed_d = armed_q;
        if (press_d) begin
            armed_d = 1'b0;
        end else if (lo_cnt_d == CNT_MAX) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
            armed_q  <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
            armed_q  <= armed_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;
    assign level = sync2_q;

endmodule

// File: rtl/op_sequencer.sv
// Board front-end: turns one debounced button press into one datapath operation,
// with operand latching, a completion timeout and a held LED result.
module op_sequencer
    import op_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESET,
    input  logic             BTNU,
    input  logic [OP_W-1:0]  SW_A,
    input  logic [OP_W-1:0]  SW_B,
    input  logic             dp_done,
    input  logic [RES_W-1:0] dp_result,
    output logic             dp_start,
    output logic [OP_W-1:0]  dp_a,
    output logic [OP_W-1:0]  dp_b,
    output logic [RES_W-1:0] LED,
    output logic             busy,
    output logic             timeout
);

    localparam int unsigned TW = (TIMEOUT_CYCLES <= 255) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic btn_press, btn_level, press_ok;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (CLK100MHZ),
        .rst    (CPU_RESET),
        .btn_raw(BTNU),
        .press  (btn_press),
        .level  (btn_level)
    );

    assign press_ok = btn_press && btn_level;

    state_e           state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic [OP_W-1:0]  dp_a_q, dp_a_d, dp_b_q, dp_b_d;
    logic [RES_W-1:0] led_q, led_d;
    logic             timeout_q, timeout_d;
    logic             dp_start_q, dp_start_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        dp_a_d    = dp_a_q;
        dp_b_d    = dp_b_q;
        led_d     = led_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (press_ok) begin
                    state_d   = StLoad;
                    timeout_d = 1'b0;
                end
            end
            StLoad: begin
                dp_a_d  = SW_A;
                dp_b_d  = SW_B;
                state_d = StStart;
            end
            StStart: begin
                tcnt_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                // dp_done takes priority over a timeout firing in the same cycle.
                if (dp_done) begin
                    led_d   = dp_result;
                    tcnt_d  = '0;
                    state_d = StShow;
                end else if (tcnt_q == TCNT_LAST) begin
                    led_d     = LED_TIMEOUT_CODE;
                    timeout_d = 1'b1;
                    tcnt_d    = '0;
                    state_d   = StShow;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            StShow: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        dp_start_d = (state_d == StStart);
        busy_d     = (state_d == StLoad) || (state_d == StStart) || (state_d == StWait);
    end

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            state_q    <= StIdle;
            tcnt_q     <= '0;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            led_q      <= '0;
            timeout_q  <= 1'b0;
            dp_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            dp_a_q     <= dp_a_d;
            dp_b_q     <= dp_b_d;
            led_q      <= led_d;
            timeout_q  <= timeout_d;
            dp_start_q <= dp_start_d;
            busy_q     <= busy_d;
        end
    end

    assign dp_start = dp_start_q;
    assign dp_a     = dp_a_q;
    assign dp_b     = dp_b_q;
    assign LED      = led_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer with a small datapath responder.
module tb_op_sequencer;

    logic       clk = 1'b0;
    logic       CPU_RESET = 1'b1;
    logic       BTNU = 1'b0;
    logic [3:0] SW_A = 4'h0;
    logic [3:0] SW_B = 4'h0;
    logic       dp_done = 1'b0;
    logic [7:0] dp_result = 8'h00;
    logic       dp_start;
    logic [3:0] dp_a, dp_b;
    logic [7:0] LED;
    logic       busy, timeout;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cnt = 0;

    // Responder configuration, set by the tests before each press.
    bit         resp_en = 1'b1;
    int         resp_delay = 6;
    logic [7:0] resp_val = 8'h00;
    int         rd;
    logic [7:0] rv;

    op_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK100MHZ(clk),
        .CPU_RESET(CPU_RESET),
        .BTNU     (BTNU),
        .SW_A     (SW_A),
        .SW_B     (SW_B),
        .dp_done  (dp_done),
        .dp_result(dp_result),
        .dp_start (dp_start),
        .dp_a     (dp_a),
        .dp_b     (dp_b),
        .LED      (LED),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (dp_start === 1'b1) start_cnt <= start_cnt + 1;

    // Datapath model: answers resp_delay cycles after seeing dp_start.
    always begin
        @(negedge clk);
        if (dp_start === 1'b1 && resp_en) begin
            rd = resp_delay;
            rv = resp_val;
            repeat (rd) @(negedge clk);
            dp_done   = 1'b1;
            dp_result = rv;
            @(negedge clk);
            dp_done   = 1'b0;
            dp_result = 8'h00;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        tick(3);
        total++; if (dp_start !== 1'b0) begin bad++; $display("FAIL reset_dp_start: got %b want 0", dp_start); end
        total++; if (dp_a !== 4'h0) begin bad++; $display("FAIL reset_dp_a: got %h want 0", dp_a); end
        total++; if (dp_b !== 4'h0) begin bad++; $display("FAIL reset_dp_b: got %h want 0", dp_b); end
        total++; if (LED !== 8'h00) begin bad++; $display("FAIL reset_led: got %h want 00", LED); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        CPU_RESET = 1'b0;
        tick(8);
    endtask

    task automatic test_single_op();
        int s0, t0, tstart;
        s0 = start_cnt;
        SW_A = 4'd3; SW_B = 4'd5;
        resp_en = 1'b1; resp_delay = 6; resp_val = 8'h08;
        tstart = -1;
        BTNU = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (i == 10) BTNU = 1'b0;
            if (dp_start === 1'b1 && tstart < 0) tstart = cyc;
        end
        total++; if (tstart - t0 !== 8) begin bad++; $display("FAIL single_start_latency: got %0d want 8", tstart - t0); end
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
        total++; if (dp_a !== 4'd3) begin bad++; $display("FAIL single_dp_a: got %h want 3", dp_a); end
        total++; if (dp_b !== 4'd5) begin bad++; $display("FAIL single_dp_b: got %h want 5", dp_b); end
        total++; if (LED !== 8'h08) begin bad++; $display("FAIL single_led: got %h want 08", LED); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL single_timeout: got %b want 0", timeout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        int s0;
        s0 = start_cnt;
        BTNU = 1'b1; tick(3); BTNU = 1'b0;
        tick(20);
        total++; if (start_cnt - s0 !== 0) begin bad++; $display("FAIL glitch_starts: got %0d want 0", start_cnt - s0); end
        total++; if (LED !== 8'h08) begin bad++; $display("FAIL glitch_led: got %h want 08", LED); end
    endtask

    task automatic test_long_hold();
        int s0;
        s0 = start_cnt;
        resp_delay = 6; resp_val = 8'h11;
        BTNU = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (i == 100) begin
                total++; if (LED !== 8'h11) begin bad++; $display("FAIL hold_led_mid: got %h want 11", LED); end
                resp_val = 8'h22;
            end
        end
        BTNU = 1'b0; tick(4);
        BTNU = 1'b1; tick(10);
        BTNU = 1'b0; tick(40);
        total++; if (start_cnt - s0 !== 2) begin bad++; $display("FAIL hold_starts: got %0d want 2", start_cnt - s0); end
        total++; if (LED !== 8'h22) begin bad++; $display("FAIL hold_led_end: got %h want 22", LED); end
    endtask

    task automatic test_timeout();
        bit seen;
        int wcnt;
        seen = 1'b0; wcnt = 0;
        resp_en = 1'b0;
        BTNU = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (i == 10) BTNU = 1'b0;
            if (dp_start === 1'b1) seen = 1'b1;
            else if (seen && busy === 1'b1) wcnt++;
        end
        total++; if (wcnt !== 16) begin bad++; $display("FAIL tmo_wait_cycles: got %0d want 16", wcnt); end
        total++; if (LED !== 8'hFF) begin bad++; $display("FAIL tmo_led: got %h want ff", LED); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %b want 1", timeout); end
        resp_en = 1'b1; resp_delay = 3; resp_val = 8'h5C;
        BTNU = 1'b1; tick(10); BTNU = 1'b0; tick(30);
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b want 0", timeout); end
        total++; if (LED !== 8'h5C) begin bad++; $display("FAIL tmo_next_led: got %h want 5c", LED); end
    endtask

    task automatic test_coincide();
        int s0;
        s0 = start_cnt;
        resp_en = 1'b1; resp_delay = 16; resp_val = 8'h2A;
        BTNU = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (i == 10) BTNU = 1'b0;
            if (i == 16) BTNU = 1'b1;
            if (i == 24) BTNU = 1'b0;
        end
        total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL coin_starts: got %0d want 1", start_cnt - s0); end
        total++; if (LED !== 8'h2A) begin bad++; $display("FAIL coin_led: got %h want 2a", LED); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL coin_timeout: got %b want 0", timeout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL coin_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        SW_A = 4'hC; SW_B = 4'hD;
        resp_en = 1'b1; resp_delay = 10; resp_val = 8'h77;
        BTNU = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (i == 10) BTNU = 1'b0;
            if (i == 11) begin
                CPU_RESET = 1'b1;
                #1;
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_async_busy: got %b want 0", busy); end
            end
            if (i == 13) CPU_RESET = 1'b0;
        end
        total++; if (LED !== 8'h00) begin bad++; $display("FAIL rmid_led: got %h want 00", LED); end
        total++; if ({dp_a, dp_b} !== 8'h00) begin bad++; $display("FAIL rmid_operands: got %h want 00", {dp_a, dp_b}); end
        total++; if ({dp_start, busy, timeout} !== 3'b000) begin bad++; $display("FAIL rmid_flags: got %b want 000", {dp_start, busy, timeout}); end
    endtask

    task automatic test_sweep();
        logic [3:0] a4, b4;
        resp_en = 1'b1; resp_delay = 1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                a4 = 4'(a); b4 = 4'(b);
                SW_A = a4; SW_B = b4;
                resp_val = {b4, a4};
                BTNU = 1'b1; tick(6); BTNU = 1'b0; tick(20);
                total++;
                if ({dp_a, dp_b, LED} !== {a4, b4, b4, a4}) begin
                    bad++;
                    $display("FAIL sweep a=%0d b=%0d: got %h want %h", a, b, {dp_a, dp_b, LED}, {a4, b4, b4, a4});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_glitch();
        test_long_hold();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
